// File: rtl/hmmm_pkg.sv
// Shared opcode, ALU-operation and sequencer-state definitions for the Hmmm
// arithmetic execute stage.
package hmmm_pkg;

   localparam logic [3:0] OPC_ADDN = 4'b0101;
   localparam logic [3:0] OPC_ADD  = 4'b0110;
   localparam logic [3:0] OPC_SUB  = 4'b0111;
   localparam logic [3:0] OPC_MUL  = 4'b1000;
   localparam logic [3:0] OPC_DIV  = 4'b1001;
   localparam logic [3:0] OPC_MOD  = 4'b1010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_MUL = 3'b010;
   localparam logic [2:0] ALU_DIV = 3'b011;
   localparam logic [2:0] ALU_MOD = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH_A = 3'd1,
      ST_FETCH_B = 3'd2,
      ST_EXEC    = 3'd3,
      ST_WB      = 3'd4
   } state_t;

endpackage

// File: rtl/hmmm_arith_decode.sv
// Combinational decode of a Hmmm arithmetic instruction word into ALU op,
// register fields and the sign-extended immediate.
module hmmm_arith_decode
   import hmmm_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 4
) (
   input  logic [15:0]               instr,
   output logic                      legal,
   output logic [2:0]                alu_op,
   output logic                      is_imm,
   output logic [RADDR_W-1:0]        x,
   output logic [RADDR_W-1:0]        y,
   output logic [RADDR_W-1:0]        z,
   output logic signed [DATA_W-1:0]  imm16
);

   assign x     = instr[8 +: RADDR_W];
   assign y     = instr[4 +: RADDR_W];
   assign z     = instr[0 +: RADDR_W];
   assign imm16 = {{(DATA_W-8){instr[7]}}, instr[7:0]};

   always_comb begin
      legal  = 1'b1;
      alu_op = ALU_ADD;
      is_imm = 1'b0;
      case (instr[15:12])
         OPC_ADDN: is_imm = 1'b1;
         OPC_ADD:  alu_op = ALU_ADD;
         OPC_SUB:  alu_op = ALU_SUB;
         OPC_MUL:  alu_op = ALU_MUL;
         OPC_DIV:  alu_op = ALU_DIV;
         OPC_MOD:  alu_op = ALU_MOD;
         default:  legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Execute-stage sequencer: fetches operands into the ALU temp registers,
// captures the ALU result and flags, and writes the result back.
module alu_sequencer
   import hmmm_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [15:0]        instr,
   output logic [RADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0]  rf_rdata,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata,
   output logic [DATA_W-1:0]  alu_tmp1,
   output logic [DATA_W-1:0]  alu_tmp2,
   output logic [2:0]         alu_op,
   output logic               alu_enable,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic               alu_zero,
   input  logic               alu_carry,
   input  logic               alu_sign,
   output logic               flag_z,
   output logic               flag_c,
   output logic               flag_s,
   output logic               done,
   output logic               illegal,
   output logic               div_zero
);

   state_t state_q, state_d;

   logic                      dec_legal;
   logic [2:0]                dec_op;
   logic                      dec_imm;
   logic [RADDR_W-1:0]        dec_x, dec_y, dec_z;
   logic signed [DATA_W-1:0]  dec_imm16;

   logic [2:0]                op_q;
   logic                      is_imm_q;
   logic [RADDR_W-1:0]        x_q, y_q, z_q;
   logic signed [DATA_W-1:0]  imm_q;
   logic signed [DATA_W-1:0]  tmp1_q, tmp2_q, result_q;
   logic                      done_q, illegal_q, div_zero_q;

   logic                      accept;
   logic [DATA_W-1:0]         rd_forced;
   logic                      div_by_zero;

   hmmm_arith_decode #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_decode (
      .instr  (instr),
      .legal  (dec_legal),
      .alu_op (dec_op),
      .is_imm (dec_imm),
      .x      (dec_x),
      .y      (dec_y),
      .z      (dec_z),
      .imm16  (dec_imm16)
   );

   assign accept      = instr_valid && instr_ready;
   // r0 is architecturally zero regardless of what the file returns
   assign rd_forced   = (rf_raddr == '0) ? '0 : rf_rdata;
   assign div_by_zero = ((op_q == ALU_DIV) || (op_q == ALU_MOD)) && (tmp2_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (accept && dec_legal) state_d = ST_FETCH_A;
         ST_FETCH_A: state_d = is_imm_q ? ST_EXEC : ST_FETCH_B;
         ST_FETCH_B: state_d = ST_EXEC;
         ST_EXEC:    state_d = div_by_zero ? ST_IDLE : ST_WB;
         ST_WB:      state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      instr_ready = 1'b0;
      rf_raddr    = '0;
      alu_enable  = 1'b0;
      rf_we       = 1'b0;
      case (state_q)
         ST_IDLE:    instr_ready = 1'b1;
         ST_FETCH_A: rf_raddr    = is_imm_q ? x_q : y_q;
         ST_FETCH_B: rf_raddr    = z_q;
         ST_EXEC:    alu_enable  = 1'b1;
         ST_WB:      rf_we       = (x_q != '0);
         default:    ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= ALU_ADD;
         is_imm_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         imm_q    <= '0;
         tmp1_q   <= '0;
         tmp2_q   <= '0;
         result_q <= '0;
         flag_z   <= 1'b0;
         flag_c   <= 1'b0;
         flag_s   <= 1'b0;
      end else begin
         if (accept && dec_legal) begin
            op_q     <= dec_op;
            is_imm_q <= dec_imm;
            x_q      <= dec_x;
            y_q      <= dec_y;
            z_q      <= dec_z;
            imm_q    <= dec_imm16;
         end
         if (state_q == ST_FETCH_A) begin
            tmp1_q <= rd_forced;
            if (is_imm_q) tmp2_q <= imm_q;
         end
         if (state_q == ST_FETCH_B) tmp2_q <= rd_forced;
         // a zero divisor leaves both the result register and flags untouched
         if ((state_q == ST_EXEC) && !div_by_zero) begin
            result_q <= alu_result;
            flag_z   <= alu_zero;
            flag_c   <= alu_carry;
            flag_s   <= alu_sign;
         end
      end
   end

   // Every EXEC retires one cycle later, either through WB or directly on divide-by-zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         done_q     <= (state_q == ST_EXEC);
         div_zero_q <= (state_q == ST_EXEC) && div_by_zero;
         illegal_q  <= accept && !dec_legal;
      end
   end

   assign alu_tmp1 = tmp1_q;
   assign alu_tmp2 = tmp2_q;
   assign alu_op   = op_q;
   assign rf_waddr = x_q;
   assign rf_wdata = result_q;
   assign done     = done_q;
   assign illegal  = illegal_q;
   assign div_zero = div_zero_q;

endmodule
